stdout_uart_tx: RTL and testbench



---
 rtl/stdout_uart_tx.sv | 133 +++++++++++++
 tb/tb_stdout_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stdout_uart_tx.sv
// 16-bit stdout word -> four uppercase hex chars + line terminator over 8N1 UART.
// Optional: define STDOUT_UART_CRLF_EN to terminate each word with CR LF instead of LF.
module stdout_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stdout_val_i,
    input  logic [15:0] stdout_data_i,
    output logic        stdout_rdy_o,
    output logic        uart_tx_o,
    output logic        busy_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
`ifdef STDOUT_UART_CRLF_EN
    localparam logic [2:0] LAST_CHAR = 3'd5;
`else
    localparam logic [2:0] LAST_CHAR = 3'd4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [15:0]     word;
    logic [2:0]      char_idx;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   baud;
    logic [7:0]      shreg;
    logic [3:0]      nib;
    logic [7:0]      cur_char;
    logic            bit_end;

    assign bit_end      = (baud == BAUD_MAX);
    assign stdout_rdy_o = rst_ni && (state == IDLE);
    assign busy_o       = (state != IDLE);

    always_comb begin
        nib = 4'h0;
        unique case (char_idx[1:0])
            2'd0: nib = word[15:12];
            2'd1: nib = word[11:8];
            2'd2: nib = word[7:4];
            2'd3: nib = word[3:0];
        endcase
    end

    // Indices past the four hex digits select the terminator bytes.
    always_comb begin
        cur_char = 8'h0A;
        if (char_idx < 3'd4) begin
            if (nib < 4'd10) cur_char = 8'h30 + {4'h0, nib};
            else             cur_char = 8'h37 + {4'h0, nib};
        end
`ifdef STDOUT_UART_CRLF_EN
        else if (char_idx == 3'd4) begin
            cur_char = 8'h0D;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            uart_tx_o <= 1'b1;
            word      <= 16'h0;
            char_idx  <= 3'd0;
            bit_cnt   <= 3'd0;
            baud      <= '0;
            shreg     <= 8'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (stdout_val_i) begin
                        word      <= stdout_data_i;
                        char_idx  <= 3'd0;
                        bit_cnt   <= 3'd0;
                        baud      <= '0;
                        uart_tx_o <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud      <= '0;
                        bit_cnt   <= 3'd0;
                        uart_tx_o <= cur_char[0];
                        shreg     <= {1'b0, cur_char[7:1]};
                        state     <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx_o <= 1'b1;
                            state     <= STOP;
                        end else begin
                            uart_tx_o <= shreg[0];
                            shreg     <= {1'b0, shreg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (char_idx == LAST_CHAR) begin
                            state <= IDLE;
                        end else begin
                            char_idx  <= char_idx + 3'd1;
                            uart_tx_o <= 1'b0;
                            state     <= START;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Scoreboard bench for stdout_uart_tx: a UART receiver monitor decodes the line
// and compares each byte against hex text predicted at accept time.
module tb_stdout_uart_tx;

    localparam int C = 4;
`ifdef STDOUT_UART_CRLF_EN
    localparam int N = 6;
`else
    localparam int N = 5;
`endif
    localparam int FRAME = 10 * N * C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        val;
    logic [15:0] data;
    logic        rdy;
    logic        tx;
    logic        busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    byte  exp_q[$];
    bit   rx_active = 0;
    int   rx_t = 0;
    logic [7:0] rx_byte = 8'h0;
    int   last_acc = 0;
    bit   have_acc = 0;
    bit   chk_gap = 0;
    bit   outstanding = 0;

    stdout_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .stdout_val_i (val),
        .stdout_data_i(data),
        .stdout_rdy_o (rdy),
        .uart_tx_o    (tx),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Reference: the word as text, most significant digit first.
    task automatic push_expected(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (int'(w) >> (12 - 4 * i)) % 16;
            if (d < 10) exp_q.push_back(byte'(48 + d));
            else        exp_q.push_back(byte'(65 + d - 10));
        end
`ifdef STDOUT_UART_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active   = 0;
            outstanding = 0;
            have_acc    = 0;
            exp_q.delete();
        end else begin
            if (outstanding && rdy) begin
                check("frame_len", cyc - last_acc, FRAME);
                check("idle_high", int'(tx), 1);
                outstanding = 0;
            end
            if (val && rdy) begin
                if (chk_gap && have_acc)
                    check("accept_gap", cyc + 1 - last_acc, FRAME + 1);
                last_acc    = cyc + 1;
                have_acc    = 1;
                outstanding = 1;
                push_expected(data);
            end
            if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1;
                    rx_t      = 0;
                    check("start_align", (cyc - last_acc) % (10 * C), 0);
                end
            end else begin
                rx_t++;
                if (rx_t % C == C / 2) begin
                    int j;
                    j = rx_t / C;
                    if (j == 0) begin
                        check("start_bit", int'(tx), 0);
                    end else if (j <= 8) begin
                        rx_byte[j-1] = tx;
                    end else begin
                        check("stop_bit", int'(tx), 1);
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL tx_byte: got 0x%0h, expected none", rx_byte);
                        end else begin
                            check("tx_byte", int'(rx_byte), int'(exp_q.pop_front()));
                        end
                        rx_active = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input bit hold);
        int n;
        n = 0;
        val  = 1'b1;
        data = w;
        while (!rdy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: rdy stuck at %0b, expected 1", rdy);
        end else begin
            @(posedge clk); #1;
        end
        if (!hold) val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || rx_active || !rdy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", int'(exp_q.size() == 0 && !rx_active && rdy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        val   = 1'b1;
        data  = 16'h1A2F;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_rdy", int'(rdy), 0);
        rst_n = 1'b1;
        #1;
        check("rdy_after_release", int'(rdy), 1);
        @(posedge clk); #1;
        check("accept_first_edge", int'(busy), 1);
        val = 1'b0;
        drain();

        send(16'h0000, 0); drain();
        send(16'hFFFF, 0); drain();
        send(16'h9A00, 0); drain();

        send(16'h1234, 1);
        repeat (60) begin
            @(posedge clk); #1;
        end
        data    = 16'hBEEF;
        chk_gap = 1;
        send(16'hBEEF, 0);
        chk_gap = 0;
        drain();

        send(16'h5A5A, 0);
        while (cyc < last_acc + 57) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_tx", int'(tx), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_rdy", int'(rdy), 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("midreset_rdy_hold", int'(rdy), 0);
        end
        rst_n = 1'b1;
        send(16'h00C3, 0); drain();

        chk_gap = 1;
        for (int i = 0; i < 20; i++) begin
            bit hold;
            hold = bit'($urandom_range(0, 1));
            send(16'($urandom), hold);
            if (!hold) begin
                chk_gap = 0;
                repeat ($urandom_range(0, 5)) begin
                    @(posedge clk); #1;
                end
            end else begin
                chk_gap = 1;
            end
        end
        val     = 1'b0;
        chk_gap = 0;
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
